// File: rtl/button_debounce_multi_pkg.sv
// Shared definitions for the multi-channel button debouncer: FSM state
// encodings and the width helper used to size the per-channel counters.
package button_debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  // Ceiling log2 of a positive count (number of bits to hold 0..value-1).
  function automatic int bdm_clog2(input int value);
    int w;
    int v;
    w = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      v = v >>> 32'sd1;
      w = w + 32'sd1;
    end
    return w;
  endfunction

  // Counter width for a terminal count of 'cycles', never below one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = bdm_clog2(cycles);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One button channel: pin synchroniser, debounce counter, press/held FSM
// with long-press and auto-repeat counters. All outputs are registered.
module button_debounce_multi_channel
  import button_debounce_multi_pkg::*;
#(
  parameter int ACTIVE_LOW        = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int REPEAT_CYCLES     = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);

  // Pin level seen while the button is not pressed.
  localparam logic RELEASED_PIN = (ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 32'sd1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 32'sd1);
  localparam logic [DW-1:0] D_ONE  = DW'(32'd1);
  localparam logic [HW-1:0] H_ONE  = HW'(32'd1);
  localparam logic [RW-1:0] R_ONE  = RW'(32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed_raw_s;

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          accept_press_s, accept_release_s;

  btn_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  // Synchroniser shift chain; resets to the released pin level so a reset
  // while pressed forces a fresh debounce afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RELEASED_PIN}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Polarity-normalised pressed indication: 1 = pressed.
  assign pressed_raw_s = sync_q[SYNC_STAGES-1] ^ RELEASED_PIN;

  // Debounce: count consecutive disagreeing cycles, any agreement restarts.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (pressed_raw_s != level_q) begin
      if (dcnt_q == D_LAST) begin
        level_d = ~level_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + D_ONE;
      end
    end else begin
      dcnt_d = '0;
    end
  end

  assign accept_press_s   = level_d & ~level_q;
  assign accept_release_s = ~level_d & level_q;

  // FSM next state, hold/repeat counters and pulse generation; an accepted
  // release always takes precedence over long/repeat thresholds.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        rcnt_d = '0;
        if (accept_press_s) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (accept_release_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hcnt_d    = '0;
          rcnt_d    = '0;
        end else if (hcnt_q == H_LAST) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          rcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + H_ONE;
        end
      end
      ST_HELD: begin
        if (accept_release_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hcnt_d    = '0;
          rcnt_d    = '0;
        end else if (!repeat_en) begin
          rcnt_d = '0;
        end else if (rcnt_q == R_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
        rcnt_d  = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_debounce_multi.sv
// Button bank front end: NUM_BTN fully independent debounce channels with
// bit-sliced ports.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int NUM_BTN           = 4,
  parameter int ACTIVE_LOW        = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int REPEAT_CYCLES     = 20000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_debounce_multi_channel #(
      .ACTIVE_LOW       (ACTIVE_LOW),
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_in       (btn_in[g]),
      .repeat_en    (repeat_en[g]),
      .btn_level    (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule
